// File: rtl/arith_share_ctrl_if.sv
// Request/response bundle for the shared arithmetic engine: two requester
// channels in, one tagged result channel out.
interface arith_share_if #(
    parameter int WIDTH = 4
);
    logic               req0_valid;
    logic               req0_ready;
    logic [2:0]         req0_op;
    logic [WIDTH-1:0]   req0_a;
    logic [WIDTH-1:0]   req0_b;

    logic               req1_valid;
    logic               req1_ready;
    logic [2:0]         req1_op;
    logic [WIDTH-1:0]   req1_a;
    logic [WIDTH-1:0]   req1_b;

    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [2*WIDTH-1:0] rsp_result;
    logic               rsp_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_err
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_err
    );
endinterface

// File: rtl/arith_share_ctrl.sv
// Round-robin arbiter plus iterative arithmetic engine shared by two requesters;
// multiply is shift-add and divide/modulo is restoring, one bit per cycle.
module arith_share_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    arith_share_if.slave bus,
    output logic         busy
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t             state;
    state_t             state_d;
    logic               last_grant;
    logic               grant;
    logic               accept;
    logic [2:0]         sel_op;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;

    logic [2:0]         op_q;
    logic               id_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;   // product accumulator, or partial remainder in the low half
    logic [2*WIDTH-1:0] x_q;   // shifted multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0]   y_q;   // multiplier shifting right, or static divisor

    logic               single_cycle;
    logic               last;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     trial;
    logic               ge;
    logic [WIDTH-1:0]   rem_w;
    logic [WIDTH-1:0]   quot_d;
    logic [2*WIDTH-1:0] result_d;
    logic               err_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
        else if (bus.req1_valid)              grant = 1'b1;
    end

    assign bus.req0_ready = (state == IDLE) && !grant;
    assign bus.req1_ready = (state == IDLE) &&  grant;
    assign accept = (state == IDLE) && (grant ? bus.req1_valid : bus.req0_valid);
    assign sel_op = grant ? bus.req1_op : bus.req0_op;
    assign sel_a  = grant ? bus.req1_a  : bus.req0_a;
    assign sel_b  = grant ? bus.req1_b  : bus.req0_b;

    assign mul_acc = acc + (y_q[0] ? x_q : '0);
    assign sum     = {1'b0, x_q[WIDTH-1:0]} + {1'b0, y_q};
    assign diff    = {1'b0, x_q[WIDTH-1:0]} - {1'b0, y_q};
    assign trial   = {acc[WIDTH-1:0], x_q[WIDTH-1]};
    assign ge      = trial >= {1'b0, y_q};
    assign rem_w   = ge ? WIDTH'(trial - {1'b0, y_q}) : trial[WIDTH-1:0];
    assign quot_d  = {x_q[WIDTH-2:0], ge};

    // Divide-by-zero and illegal ops finish in one cycle just like add/sub.
    assign single_cycle = !(op_q == OP_MUL || op_q == OP_DIV || op_q == OP_MOD) ||
                          ((op_q == OP_DIV || op_q == OP_MOD) && y_q == '0);
    assign last = single_cycle || (cnt == CW'(WIDTH - 1));

    always_comb begin
        result_d = '0;
        err_d    = 1'b0;
        case (op_q)
            OP_ADD: result_d = {{(WIDTH-1){1'b0}}, sum};
            OP_SUB: result_d = {{(WIDTH-1){1'b0}}, diff};
            OP_MUL: result_d = mul_acc;
            OP_DIV: begin
                err_d    = (y_q == '0);
                result_d = {{WIDTH{1'b0}}, err_d ? {WIDTH{1'b1}} : quot_d};
            end
            OP_MOD: begin
                err_d    = (y_q == '0);
                result_d = {{WIDTH{1'b0}}, err_d ? x_q[WIDTH-1:0] : rem_w};
            end
            default: err_d = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept)        state_d = EXEC;
            EXEC:    if (last)          state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant     <= 1'b1;
            op_q           <= '0;
            id_q           <= 1'b0;
            cnt            <= '0;
            acc            <= '0;
            x_q            <= '0;
            y_q            <= '0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_err    <= 1'b0;
        end else if (accept) begin
            last_grant <= grant;
            op_q       <= sel_op;
            id_q       <= grant;
            cnt        <= '0;
            acc        <= '0;
            x_q        <= {{WIDTH{1'b0}}, sel_a};
            y_q        <= sel_b;
        end else if (state == EXEC) begin
            cnt <= cnt + CW'(1);
            if (op_q == OP_MUL) begin
                acc <= mul_acc;
                x_q <= x_q << 1;
                y_q <= y_q >> 1;
            end else if (op_q == OP_DIV || op_q == OP_MOD) begin
                acc <= {{WIDTH{1'b0}}, rem_w};
                x_q <= {{WIDTH{1'b0}}, quot_d};
            end
            if (last) begin
                bus.rsp_id     <= id_q;
                bus.rsp_result <= result_d;
                bus.rsp_err    <= err_d;
            end
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_arith_share_ctrl.sv
// Directed bench for arith_share_ctrl: vector table for single operations,
// plus sequences for alternation, response backpressure and mid-op reset.
module tb_arith_share_ctrl;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    int checks = 0;
    int errors = 0;
    int last_port = 1;

    arith_share_if #(.WIDTH(W)) bus ();

    arith_share_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         port;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] res;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input int port, input logic v, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b);
        if (port == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Returns at the negedge where rsp_valid is first seen; lat counts negedges since acceptance.
    task automatic wait_rsp(output int lat);
        bit seen = 1'b0;
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        @(negedge clk);
        drive(v.port, 1'b1, v.op, v.a, v.b);
        #1;
        check($sformatf("v%0d_own_ready", idx), v.port == 0 ? bus.req0_ready : bus.req1_ready, 1);
        check($sformatf("v%0d_other_ready", idx), v.port == 0 ? bus.req1_ready : bus.req0_ready, 0);
        @(posedge clk);
        #1 drive(v.port, 1'b0, 3'd0, 4'd0, 4'd0);
        wait_rsp(lat);
        check($sformatf("v%0d_latency", idx), lat, v.lat);
        check($sformatf("v%0d_result", idx), bus.rsp_result, v.res);
        check($sformatf("v%0d_id", idx), bus.rsp_id, v.port);
        check($sformatf("v%0d_err", idx), bus.rsp_err, v.err);
        @(negedge clk);
        check($sformatf("v%0d_rsp_drop", idx), bus.rsp_valid, 0);
        last_port = v.port;
    endtask

    initial begin
        int lat;
        int done [2];
        int rsps;
        int exp_port;
        int port;
        bit adv [2];
        int pend_id;
        logic [7:0] pend_res;
        bit stray;

        vecs[0]  = '{0, 3'd0, 4'd3,  4'd8,  8'd11,  1'b0, 2};
        vecs[1]  = '{1, 3'd1, 4'd3,  4'd8,  8'd27,  1'b0, 2};
        vecs[2]  = '{0, 3'd2, 4'd15, 4'd15, 8'd225, 1'b0, 5};
        vecs[3]  = '{0, 3'd2, 4'd4,  4'd7,  8'd28,  1'b0, 5};
        vecs[4]  = '{1, 3'd2, 4'd0,  4'd9,  8'd0,   1'b0, 5};
        vecs[5]  = '{0, 3'd3, 4'd15, 4'd4,  8'd3,   1'b0, 5};
        vecs[6]  = '{1, 3'd4, 4'd15, 4'd4,  8'd3,   1'b0, 5};
        vecs[7]  = '{0, 3'd3, 4'd2,  4'd11, 8'd0,   1'b0, 5};
        vecs[8]  = '{0, 3'd4, 4'd2,  4'd11, 8'd2,   1'b0, 5};
        vecs[9]  = '{1, 3'd3, 4'd12, 4'd0,  8'd15,  1'b1, 2};
        vecs[10] = '{0, 3'd7, 4'd5,  4'd6,  8'd0,   1'b1, 2};
        vecs[11] = '{1, 3'd4, 4'd13, 4'd0,  8'd13,  1'b1, 2};
        vecs[12] = '{0, 3'd3, 4'd15, 4'd1,  8'd15,  1'b0, 5};
        vecs[13] = '{1, 3'd4, 4'd14, 4'd3,  8'd2,   1'b0, 5};
        vecs[14] = '{0, 3'd0, 4'd15, 4'd15, 8'd30,  1'b0, 2};
        vecs[15] = '{1, 3'd1, 4'd0,  4'd15, 8'd17,  1'b0, 2};

        drive(0, 1'b0, 3'd0, 4'd0, 4'd0);
        drive(1, 1'b0, 3'd0, 4'd0, 4'd0);
        bus.rsp_ready = 1'b1;

        // Reset state
        #1;
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_result", bus.rsp_result, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // Both requesters streaming: port0 adds k+1, port1 multiplies (k+1)*3
        done[0] = 0; done[1] = 0; adv[0] = 0; adv[1] = 0;
        rsps = 0; pend_id = 0; pend_res = '0;
        exp_port = 1 - last_port;
        @(negedge clk);
        drive(0, 1'b1, 3'd0, 4'd0, 4'd1);
        drive(1, 1'b1, 3'd2, 4'd1, 4'd3);
        for (int cyc = 0; cyc < 300 && rsps < 8; cyc++) begin
            if (cyc != 0) @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (adv[p]) begin
                    adv[p] = 0;
                    if (done[p] < 4) begin
                        if (p == 0) drive(0, 1'b1, 3'd0, 4'(done[0]), 4'd1);
                        else        drive(1, 1'b1, 3'd2, 4'(done[1] + 1), 4'd3);
                    end else begin
                        drive(p, 1'b0, 3'd0, 4'd0, 4'd0);
                    end
                end
            end
            #1;
            if (bus.rsp_valid) begin
                check("alt_rsp_id", bus.rsp_id, pend_id);
                check("alt_rsp_result", bus.rsp_result, pend_res);
                rsps++;
            end
            check("alt_ready_excl", bus.req0_ready & bus.req1_ready, 0);
            if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
                port = (bus.req1_valid && bus.req1_ready) ? 1 : 0;
                check("alt_grant_order", port, exp_port);
                check("alt_other_ready", port == 0 ? bus.req1_ready : bus.req0_ready, 0);
                pend_id  = port;
                pend_res = (port == 0) ? 8'(done[0] + 1) : 8'((done[1] + 1) * 3);
                done[port]++;
                adv[port] = 1;
                exp_port  = 1 - port;
                last_port = port;
            end
        end
        check("alt_rsp_count", rsps, 8);

        // Response backpressure after a multiply
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        drive(0, 1'b1, 3'd2, 4'd6, 4'd5);
        @(posedge clk);
        #1 drive(0, 1'b0, 3'd0, 4'd0, 4'd0);
        wait_rsp(lat);
        check("hold_latency", lat, 5);
        drive(1, 1'b1, 3'd0, 4'd2, 4'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_result", bus.rsp_result, 30);
            check("hold_id", bus.rsp_id, 0);
            check("hold_busy", busy, 1);
            check("hold_no_ready", bus.req0_ready | bus.req1_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("release_busy", busy, 0);
        check("release_valid", bus.rsp_valid, 0);
        check("release_ready1", bus.req1_ready, 1);
        @(posedge clk);
        #1 drive(1, 1'b0, 3'd0, 4'd0, 4'd0);
        wait_rsp(lat);
        check("post_hold_latency", lat, 2);
        check("post_hold_result", bus.rsp_result, 4);
        check("post_hold_id", bus.rsp_id, 1);
        @(negedge clk);

        // Reset during the second EXEC cycle of a multiply
        drive(0, 1'b1, 3'd2, 4'd7, 4'd3);
        @(posedge clk);
        #1 drive(0, 1'b0, 3'd0, 4'd0, 4'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", bus.rsp_valid, 0);
        check("midrst_result", bus.rsp_result, 0);
        check("midrst_id", bus.rsp_id, 0);
        check("midrst_err", bus.rsp_err, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) stray = 1'b1;
        end
        check("midrst_no_rsp", stray, 0);
        drive(0, 1'b1, 3'd0, 4'd1, 4'd2);
        drive(1, 1'b1, 3'd0, 4'd5, 4'd5);
        #1;
        check("midrst_tie_ready0", bus.req0_ready, 1);
        check("midrst_tie_ready1", bus.req1_ready, 0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 3'd0, 4'd0, 4'd0);
        drive(1, 1'b0, 3'd0, 4'd0, 4'd0);
        wait_rsp(lat);
        check("midrst_next_latency", lat, 2);
        check("midrst_next_result", bus.rsp_result, 3);
        check("midrst_next_id", bus.rsp_id, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/arith_share_ctrl.md
# arith_share_ctrl

Sequencer and arbiter that shares one arithmetic engine between two requesters. Each requester issues a single operation (add, subtract, multiply, divide, modulo) over a valid/ready handshake. The block grants requesters round-robin, runs multi-cycle multiply and divide iteratively on one shared datapath, and returns a tagged result on a valid/ready response channel. It sits between operand producers and the result consumer in place of per-requester combinational arithmetic.

## Interface
- WIDTH, 4, operand width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid / req1_valid  input  1  request present
- req0_ready / req1_ready  output  1  request accepted when valid&ready
- req0_op / req1_op  input  3  000 add, 001 sub, 010 mul, 011 div, 100 mod, others illegal
- req0_a, req0_b / req1_a, req1_b  input  WIDTH  unsigned operands
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester index of response
- rsp_result  output  2*WIDTH  result, zero-extended
- rsp_err  output  1  divide by zero or illegal op
- busy  output  1  state ≠ IDLE

## Operation
- FSM: IDLE → EXEC (n cycles) → RESP → IDLE.
- IDLE: grant = sole valid requester; if both valid, requester ≠ last_grant. reqN_ready = (state==IDLE) & (grant==N), combinational. Both readys are never high together.
- On acceptance: latch op, a, b, id. Update last_grant. Go to EXEC.
- Payload is sampled only at acceptance. Requesters hold valid and payload until ready.
- add: result = a+b (WIDTH+1 bits), n=1.
- sub: result = (a−b) mod 2^(WIDTH+1), i.e. (WIDTH+1)-bit two's complement, zero-extended, n=1.
- mul: shift-add, one partial product per cycle, 2*WIDTH-bit product, n=WIDTH.
- div/mod: restoring division, one quotient bit per cycle, n=WIDTH. div returns quotient, mod returns remainder.
- b==0 for div/mod: n=1, rsp_err=1. div result = 2^WIDTH−1. mod result = a.
- Illegal op: n=1, rsp_err=1, result 0.
- RESP: rsp_valid=1. rsp_id/rsp_result/rsp_err are held stable until rsp_valid&rsp_ready. Return to IDLE on that edge.
- No new request is accepted while EXEC or RESP.
- busy=1 in EXEC and RESP.

## Timing
- Reset (async assert, any state): state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, busy=0, last_grant=1 (req0 wins first contest), datapath registers 0. An in-flight operation is discarded and no response is produced.
- Acceptance in cycle C0; EXEC occupies C1..Cn; rsp_valid=1 from C(n+1).
- add/sub/err latency: rsp_valid 2 cycles after acceptance. mul/div/mod: WIDTH+1 cycles.
- With rsp_ready=1 in C(n+1), IDLE in C(n+2), where the next acceptance is possible. Peak throughput for add is one op per 3 cycles.
- rsp_ready low: stay in RESP indefinitely, outputs frozen, both readys low.
- Simultaneous valids with both held: grants strictly alternate.
- A valid that drops before acceptance is ignored; arbitration is re-evaluated each IDLE cycle.
- rsp_ready is ignored when rsp_valid=0.

## Test plan
- req0 add a=3,b=8 → rsp_result=11, rsp_id=0, rsp_err=0, rsp_valid 2 cycles after acceptance. req1 sub a=3,b=8 → rsp_result=27 (5'h1B), rsp_id=1.
- req0 mul a=15,b=15 → 225 after 5 cycles. mul a=4,b=7 → 28. mul a=0,b=9 → 0.
- div a=15,b=4 → 3; mod a=15,b=4 → 3; div a=2,b=11 → 0; mod a=2,b=11 → 2; div a=12,b=0 → 15 with rsp_err=1, latency 2; op=111 → 0 with rsp_err=1.
- Both requesters valid continuously with 4 ops each → grants ordered 0,1,0,1,…. rsp_id matches. The non-granted ready stays low.
- rsp_ready held low 5 cycles after a mul → rsp_valid and outputs stable, busy=1, no acceptance. Release → IDLE the next cycle.
- Deassert rst_n mid-mul (EXEC cycle 2) → all outputs 0 immediately. No response after release. The next request gets normal latency, and req0 wins a tie.
